run_length_stage: RTL and testbench

Zero-run-length encoder for quantised DCT coefficients in the compressor datapath. It takes an 8x8 block in zig-zag order, two coefficients per beat (32 beats per block), and converts it into (zero-run, value) tokens. Tokens are buffered in an internal FIFO and emitted one per cycle, each flagged by `rsync`. The stage sits between the quantiser/zig-zag stage and the entropy packer.

---
 rtl/run_length_stage.sv | 174 +++++++++++++++++
 tb/tb_run_length_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_length_stage.sv
// ---------------------------------------------------------------------------
// run_length_stage
//
// Zero-run-length encoder for quantised DCT coefficients. Consumes an 8x8
// block in zig-zag order, two coefficients per beat (32 beats per block),
// and turns it into (zero-run, value) tokens. An end-of-block token (0, 0)
// closes any block that ends in zeros. Tokens are queued in a 64-entry FIFO
// and presented one per cycle on o_data0/o_data1, qualified by rsync.
//
// Parameters
//   DATA_WIDTH    coefficient width (signed); also width of the output ports
//   OUTPUT_WIDTH  width of each field of a FIFO entry (>= DATA_WIDTH)
//
// Ports
//   i_clk     clock, rising edge
//   i_resetn  asynchronous active-low reset
//   i_data0   coefficient at zig-zag index 2k of the current beat
//   i_data1   coefficient at zig-zag index 2k+1 of the current beat
//   wen       beat valid; the pair is consumed on each rising edge it is high
//   o_data0   run: number of zero coefficients preceding the value
//   o_data1   nonzero coefficient value, or 0 for an end-of-block token
//   rsync     o_data0/o_data1 carry a fresh token this cycle
// ---------------------------------------------------------------------------
module run_length_stage #(
   parameter int DATA_WIDTH   = 15,
   parameter int OUTPUT_WIDTH = 16
) (
   input  logic                         i_clk,
   input  logic                         i_resetn,
   input  logic signed [DATA_WIDTH-1:0] i_data0,
   input  logic signed [DATA_WIDTH-1:0] i_data1,
   input  logic                         wen,
   output logic        [DATA_WIDTH-1:0] o_data0,
   output logic signed [DATA_WIDTH-1:0] o_data1,
   output logic                         rsync
);

   localparam int DEPTH   = 64;
   localparam int AW      = 6;
   localparam int ENTRY_W = 2 * OUTPUT_WIDTH;

   // Field packing helpers: run is zero-extended, value sign-extended.
   function automatic logic [OUTPUT_WIDTH-1:0] zext_run(input logic [5:0] run);
      return OUTPUT_WIDTH'(run);
   endfunction

   function automatic logic [OUTPUT_WIDTH-1:0] sext_val(input logic signed [DATA_WIDTH-1:0] val);
      return OUTPUT_WIDTH'(val);
   endfunction

   function automatic logic [ENTRY_W-1:0] pack_token(input logic [5:0]                  run,
                                                     input logic signed [DATA_WIDTH-1:0] val);
      return {zext_run(run), sext_val(val)};
   endfunction

   // Block position and zero-run state
   logic [4:0] beat_cnt;
   logic [5:0] run_cnt;

   // ---- p0: token formation for the current beat ----
   logic               nz0_p0, nz1_p0, last_p0, eob_p0;
   logic [6:0]         run_in_p0, run_a_p0, run_b_p0;
   logic [5:0]         run_nxt_p0;
   logic [1:0]         n_tok_p0;
   logic [ENTRY_W-1:0] tok0_p0, tok1_p0, tok_eob_p0;
   logic [ENTRY_W-1:0] slot_a_p0, slot_b_p0;

   // Run arithmetic is one bit wider so that an all-zero block (64 zeros)
   // still registers a nonzero trailing run and gets its EOB.
   always_comb begin
      nz0_p0     = (i_data0 != '0);
      nz1_p0     = (i_data1 != '0);
      last_p0    = (beat_cnt == 5'd31);
      run_in_p0  = {1'b0, run_cnt};
      run_a_p0   = nz0_p0 ? 7'd0 : run_in_p0 + 7'd1;
      run_b_p0   = nz1_p0 ? 7'd0 : run_a_p0 + 7'd1;
      eob_p0     = last_p0 && (run_b_p0 != 7'd0);
      run_nxt_p0 = last_p0 ? 6'd0 : run_b_p0[5:0];

      tok0_p0    = pack_token(run_in_p0[5:0], i_data0);
      tok1_p0    = pack_token(run_a_p0[5:0], i_data1);
      tok_eob_p0 = '0;

      n_tok_p0   = {1'b0, nz0_p0} + {1'b0, nz1_p0} + {1'b0, eob_p0};

      // Compact the (up to two) tokens into slots a/b in emission order.
      // EOB can only coexist with a lane-0 token, since a nonzero lane 1
      // leaves no trailing run.
      if (nz0_p0)      slot_a_p0 = tok0_p0;
      else if (nz1_p0) slot_a_p0 = tok1_p0;
      else             slot_a_p0 = tok_eob_p0;
      slot_b_p0 = nz1_p0 ? tok1_p0 : tok_eob_p0;
   end

   // ---- p1: token FIFO ----
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW:0]        wr_ptr_p1, rd_ptr_p1, count_p1, free_p1;
   logic [1:0]         n_acc_p1;
   logic               pop_p1;
   logic [AW-1:0]      wr_idx_a_p1, wr_idx_b_p1, rd_idx_p1;

   // Free space is judged before the edge; a same-edge pop does not make
   // room for this beat's tokens. With one slot left, the first token wins.
   always_comb begin
      count_p1    = wr_ptr_p1 - rd_ptr_p1;
      free_p1     = 7'(DEPTH) - count_p1;
      pop_p1      = (count_p1 != '0);
      wr_idx_a_p1 = wr_ptr_p1[AW-1:0];
      wr_idx_b_p1 = wr_ptr_p1[AW-1:0] + AW'(1);
      rd_idx_p1   = rd_ptr_p1[AW-1:0];
      n_acc_p1    = 2'd0;
      if (wen) begin
         if (free_p1 >= 7'd2)
            n_acc_p1 = n_tok_p0;
         else if ((free_p1 == 7'd1) && (n_tok_p0 != 2'd0))
            n_acc_p1 = 2'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         beat_cnt  <= '0;
         run_cnt   <= '0;
         wr_ptr_p1 <= '0;
         rd_ptr_p1 <= '0;
      end else begin
         if (wen) begin
            beat_cnt <= beat_cnt + 5'd1;
            run_cnt  <= run_nxt_p0;
         end
         wr_ptr_p1 <= wr_ptr_p1 + (AW+1)'(n_acc_p1);
         if (pop_p1)
            rd_ptr_p1 <= rd_ptr_p1 + (AW+1)'(1);
      end
   end

   // Storage carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge i_clk) begin
      if (n_acc_p1 != 2'd0)
         mem[wr_idx_a_p1] <= slot_a_p0;
      if (n_acc_p1 == 2'd2)
         mem[wr_idx_b_p1] <= slot_b_p0;
   end

   // ---- p2: registered output ----
   logic [OUTPUT_WIDTH-1:0] run_p2, val_p2;
   logic                    vld_p2;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         run_p2 <= '0;
         val_p2 <= '0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p2 <= pop_p1;
         if (pop_p1)
            {run_p2, val_p2} <= mem[rd_idx_p1];
      end
   end

   assign o_data0 = run_p2[DATA_WIDTH-1:0];
   assign o_data1 = val_p2[DATA_WIDTH-1:0];
   assign rsync   = vld_p2;

   // Extension bits above the port width are carried but not presented.
   generate
      if (OUTPUT_WIDTH > DATA_WIDTH) begin : g_hi_bits
         logic unused_hi;
         assign unused_hi = ^{run_p2[OUTPUT_WIDTH-1:DATA_WIDTH],
                              val_p2[OUTPUT_WIDTH-1:DATA_WIDTH]};
      end
   endgenerate

endmodule

// File: tb/tb_run_length_stage.sv
// ---------------------------------------------------------------------------
// tb_run_length_stage
//
// Directed sequence of blocks (hand-picked and random) driven into
// run_length_stage. A reference model expands each coefficient into tokens
// by the zero-run rules, keeps the FIFO as a queue of tokens, and predicts
// rsync/o_data0/o_data1 after every clock edge.
// ---------------------------------------------------------------------------
module tb_run_length_stage;

   localparam int DW = 15;

   logic          clk = 1'b0;
   logic          i_resetn;
   logic [DW-1:0] i_data0, i_data1;
   logic          wen;
   logic [DW-1:0] o_data0, o_data1;
   logic          rsync;

   always #5 clk = ~clk;

   run_length_stage #(
      .DATA_WIDTH   (DW),
      .OUTPUT_WIDTH (16)
   ) dut (
      .i_clk    (clk),
      .i_resetn (i_resetn),
      .i_data0  (i_data0),
      .i_data1  (i_data1),
      .wen      (wen),
      .o_data0  (o_data0),
      .o_data1  (o_data1),
      .rsync    (rsync)
   );

   // Reference model state
   logic [2*DW-1:0] fifo_q[$];
   logic [2*DW-1:0] new_tok[$];
   int              zeros;
   int              idx;
   logic            exp_rsync;
   logic [DW-1:0]   exp_d0, exp_d1;
   int              n_drop;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [DW-1:0] blk[64];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      assert (got === want) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".rsync"}, 32'(rsync), 32'(exp_rsync));
      check({tag, ".run"}, 32'(o_data0), 32'(exp_d0));
      check({tag, ".value"}, 32'(o_data1), 32'(exp_d1));
   endtask

   task automatic model_reset();
      fifo_q.delete();
      zeros     = 0;
      idx       = 0;
      exp_rsync = 1'b0;
      exp_d0    = '0;
      exp_d1    = '0;
   endtask

   // One coefficient in zig-zag order; EOB closes a block with trailing zeros.
   task automatic model_coef(input logic [DW-1:0] c);
      if (c != '0) begin
         new_tok.push_back({DW'(zeros), c});
         zeros = 0;
      end else begin
         zeros++;
      end
      idx++;
      if (idx == 64) begin
         if (zeros > 0) new_tok.push_back('0);
         zeros = 0;
         idx   = 0;
      end
   endtask

   task automatic model_edge(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic w);
      int              had;
      logic [2*DW-1:0] t;
      if (!i_resetn) begin
         model_reset();
         return;
      end
      had = fifo_q.size();
      if (had > 0) begin
         t         = fifo_q.pop_front();
         exp_rsync = 1'b1;
         exp_d0    = t[2*DW-1:DW];
         exp_d1    = t[DW-1:0];
      end else begin
         exp_rsync = 1'b0;
      end
      if (w) begin
         new_tok.delete();
         model_coef(a);
         model_coef(b);
         foreach (new_tok[i]) begin
            if (i < 64 - had) fifo_q.push_back(new_tok[i]);
            else n_drop++;
         end
      end
   endtask

   task automatic step(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic w,
                       input string tag);
      i_data0 = a;
      i_data1 = b;
      wen     = w;
      @(posedge clk);
      model_edge(a, b, w);
      #1;
      check_outputs(tag);
   endtask

   function automatic logic [DW-1:0] nz_rand();
      logic [DW-1:0] v;
      v = DW'($urandom);
      if (v == '0) v = 15'd1;
      return v;
   endfunction

   task automatic gen_block(input int dens);
      for (int i = 0; i < 64; i++)
         blk[i] = ($urandom_range(99) < dens) ? nz_rand() : '0;
   endtask

   task automatic clear_block();
      for (int i = 0; i < 64; i++) blk[i] = '0;
   endtask

   task automatic send_block(input int gap_pct, input string tag);
      for (int b = 0; b < 32; b++) begin
         while ($urandom_range(99) < gap_pct)
            step(DW'($urandom), DW'($urandom), 1'b0, {tag, ".gap"});
         step(blk[2*b], blk[2*b+1], 1'b1, tag);
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++)
         step(DW'($urandom), DW'($urandom), 1'b0, tag);
   endtask

   // Drop reset between edges and check the outputs clear immediately.
   task automatic async_reset(input int hold_cycles, input string tag);
      #2;
      i_resetn = 1'b0;
      #1;
      model_reset();
      check_outputs({tag, ".async"});
      for (int i = 0; i < hold_cycles; i++)
         step(DW'($urandom), DW'($urandom), 1'b1, {tag, ".hold"});
      #3;
      i_resetn = 1'b1;
   endtask

   initial begin
      i_resetn = 1'b0;
      i_data0  = '0;
      i_data1  = '0;
      wen      = 1'b0;
      n_drop   = 0;
      model_reset();

      // Reset held with wen high: nothing comes out
      for (int i = 0; i < 3; i++)
         step(DW'($urandom), DW'($urandom), 1'b1, "reset_hold");
      #3;
      i_resetn = 1'b1;
      idle(3, "post_reset_idle");

      // Beat 0 = (3, -2), rest of block zero: (0,3), (0,-2), then EOB
      clear_block();
      blk[0] = 15'd3;
      blk[1] = 15'h7FFE;
      send_block(0, "all_nonzero_beat");
      idle(4, "drain_a");

      // Zero run across beats: (0,0),(0,7) -> (3,7), then EOB
      clear_block();
      blk[3] = 15'd7;
      send_block(0, "zero_runs");
      idle(4, "drain_b");

      // Only index 0 nonzero: (0,12) then EOB
      clear_block();
      blk[0] = 15'd12;
      send_block(0, "end_of_block");
      idle(4, "drain_c");

      // Block with no trailing zeros (index 63 nonzero): no EOB
      clear_block();
      blk[10] = 15'h4000;
      blk[63] = 15'h3FFF;
      send_block(0, "no_eob");
      idle(4, "drain_d");

      // Same sparse block four times back-to-back
      gen_block(25);
      for (int r = 0; r < 4; r++) send_block(0, "repeat_block");
      idle(40, "drain_e");

      // Random sparse blocks with idle gaps
      for (int r = 0; r < 4; r++) begin
         gen_block($urandom_range(40));
         send_block(20, "random_gaps");
      end
      idle(40, "drain_f");

      // Dense blocks sent continuously: FIFO fills and drops tokens
      for (int r = 0; r < 3; r++) begin
         gen_block(100);
         send_block(0, "overflow");
      end

      // Reset mid-block while full
      gen_block(100);
      for (int b = 0; b < 10; b++)
         step(blk[2*b], blk[2*b+1], 1'b1, "overflow_partial");
      async_reset(2, "mid_block_reset");
      idle(3, "after_reset_idle");

      // First beat after release is index 0 again
      clear_block();
      blk[0] = 15'd12;
      blk[5] = 15'h7FFF;
      send_block(0, "realign");
      idle(70, "drain_final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
